// File: rtl/btn_cond_pkg.sv
// Shared types and defaults for the push-button conditioner.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package btn_cond_pkg;

    typedef enum logic {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } lane_state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int CNT_W_DEF           = 16;

endpackage

// File: rtl/btn_debounce_lane.sv
// One button lane: 2-FF synchronizer, counter debouncer, rise/fall one-shots, toggle latch.
// Latency: level follows a clean raw step after 2 + DEBOUNCE_CYCLES clocks; rise/fall/toggle one clock later.
// Backpressure: none; free-running, every output is valid every cycle.
module btn_debounce_lane
    import btn_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic toggle,
    output logic busy
);

    // The counter must be able to hold DEBOUNCE_CYCLES-1 without wrapping.
    if (DEBOUNCE_CYCLES < 2 || CNT_W < 1 ||
        (CNT_W < 31 && (1 << CNT_W) <= DEBOUNCE_CYCLES)) begin : g_bad_cfg
        $error("btn_debounce_lane: CNT_W too small for DEBOUNCE_CYCLES or DEBOUNCE_CYCLES < 2");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    lane_state_t      state;
    lane_state_t      state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             level_nxt;
    logic             level_prev;

    // Two-flop synchronizer; only s2 is trusted by the debouncer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s2_src(s1);
        end
    end

    function automatic logic s2_src(input logic v);
        return v;
    endfunction

    // FSM state, stability counter and accepted level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= STABLE;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            level <= level_nxt;
        end
    end

    // Next state: a differing sample opens a check window; any sample that
    // agrees with the current level again aborts it without touching outputs.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = level;
        case (state)
            STABLE: begin
                cnt_nxt = '0;
                if (s2 != level) begin
                    state_nxt = CHECK;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            CHECK: begin
                if (s2 == level) begin
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    level_nxt = s2;
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = STABLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Edge one-shots and toggle, registered one cycle after level changes.
    // level_prev is cleared by reset together with level, so a reset never
    // manufactures a fall pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_prev <= 1'b0;
            rise       <= 1'b0;
            fall       <= 1'b0;
            toggle     <= 1'b0;
        end else begin
            level_prev <= level;
            rise       <= level & ~level_prev;
            fall       <= ~level & level_prev;
            if (level & ~level_prev) begin
                toggle <= ~toggle;
            end
        end
    end

    assign busy = (state == CHECK);

endmodule

// File: rtl/push_button_conditioner.sv
// N independent debounced push-button lanes plus a combined busy flag.
// Latency: 2 + DEBOUNCE_CYCLES clocks raw-to-level; pulses and toggle one clock after level.
// Backpressure: none; outputs are continuous levels and single-cycle pulses.
module push_button_conditioner
    import btn_cond_pkg::*;
#(
    parameter int NUM_BUTTONS     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_BUTTONS-1:0] btn_raw,
    output logic [NUM_BUTTONS-1:0] btn_level,
    output logic [NUM_BUTTONS-1:0] btn_rise,
    output logic [NUM_BUTTONS-1:0] btn_fall,
    output logic [NUM_BUTTONS-1:0] btn_toggle,
    output logic                   any_busy
);

    logic [NUM_BUTTONS-1:0] busy;

    // One lane per button, no interaction between lanes.
    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_lane
        btn_debounce_lane #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw    (btn_raw[i]),
            .level  (btn_level[i]),
            .rise   (btn_rise[i]),
            .fall   (btn_fall[i]),
            .toggle (btn_toggle[i]),
            .busy   (busy[i])
        );
    end

    // Each lane's busy comes straight from its state register.
    assign any_busy = |busy;

endmodule

// File: tb/tb_push_button_conditioner.sv
// Directed bench for push_button_conditioner with default parameters.
// Latency: n/a.
// Backpressure: n/a.
module tb_push_button_conditioner;

    logic       clk;
    logic       rst_n;
    logic [1:0] btn_raw;
    logic [1:0] btn_level;
    logic [1:0] btn_rise;
    logic [1:0] btn_fall;
    logic [1:0] btn_toggle;
    logic       any_busy;

    int checks;
    int passed;

    push_button_conditioner #(
        .NUM_BUTTONS     (2),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_rise   (btn_rise),
        .btn_fall   (btn_fall),
        .btn_toggle (btn_toggle),
        .any_busy   (any_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [8:0] obs;
    assign obs = {btn_level, btn_rise, btn_fall, btn_toggle, any_busy};

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        btn_raw = 2'b00;
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    // Edge k is the k-th rising edge after btn_raw / rst_n was changed.
    task automatic test_reset();
        logic [8:0] exp;
        rst_n   = 1'b0;
        btn_raw = 2'b11;
        tick(3);
        checks++;
        if (obs !== 9'b0) $display("FAIL reset_hold obs=%b expected=%b", obs, 9'b0);
        else passed++;
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            exp = {(k >= 6) ? 2'b11 : 2'b00, (k == 7) ? 2'b11 : 2'b00, 2'b00,
                   (k >= 7) ? 2'b11 : 2'b00, (k >= 3 && k <= 5)};
            checks++;
            if (obs !== exp) $display("FAIL reset_release k=%0d obs=%b expected=%b", k, obs, exp);
            else passed++;
        end
    endtask

    task automatic test_clean_press();
        logic [8:0] exp;
        do_reset();
        btn_raw = 2'b01;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            exp = {1'b0, k >= 6, 1'b0, k == 7, 2'b00, 1'b0, k >= 7, (k >= 3 && k <= 5)};
            checks++;
            if (obs !== exp) $display("FAIL press k=%0d obs=%b expected=%b", k, obs, exp);
            else passed++;
        end
        btn_raw = 2'b00;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            exp = {1'b0, k < 6, 2'b00, 1'b0, k == 7, 2'b01, (k >= 3 && k <= 5)};
            checks++;
            if (obs !== exp) $display("FAIL release k=%0d obs=%b expected=%b", k, obs, exp);
            else passed++;
        end
    endtask

    // Lane 1 raw: 1,0,1,0 then 0 -> CHECK is entered at edges 3 and 5 and
    // abandoned one edge later each time.
    task automatic test_bounce();
        logic [8:0] exp;
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            btn_raw = {(k == 1 || k == 3), 1'b0};
            tick(1);
            exp = {8'b0, (k == 3 || k == 5)};
            checks++;
            if (obs !== exp) $display("FAIL bounce k=%0d obs=%b expected=%b", k, obs, exp);
            else passed++;
        end
    endtask

    // Raw high for 3 clocks is rejected; 4 clocks is accepted, and the
    // immediate drop afterwards is accepted too (level high for edges 6..9).
    task automatic test_boundary();
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            btn_raw = {1'b0, k <= 3};
            tick(1);
            checks++;
            if (btn_level !== 2'b00) $display("FAIL boundary3 k=%0d level=%b expected=00", k, btn_level);
            else passed++;
        end
        for (int k = 1; k <= 11; k++) begin
            btn_raw = {1'b0, k <= 4};
            tick(1);
            checks++;
            if (btn_level !== {1'b0, (k >= 6 && k <= 9)})
                $display("FAIL boundary4 k=%0d level=%b expected=%b", k, btn_level, {1'b0, (k >= 6 && k <= 9)});
            else passed++;
        end
    endtask

    // Joint press counts as the first press of button 0; three more follow,
    // so toggle ends at lane1=1, lane0=0.
    task automatic test_simultaneous();
        logic [8:0] exp;
        logic       t0;
        do_reset();
        btn_raw = 2'b11;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            exp = {(k >= 6) ? 2'b11 : 2'b00, (k == 7) ? 2'b11 : 2'b00, 2'b00,
                   (k >= 7) ? 2'b11 : 2'b00, (k >= 3 && k <= 5)};
            checks++;
            if (obs !== exp) $display("FAIL simul k=%0d obs=%b expected=%b", k, obs, exp);
            else passed++;
        end
        t0 = 1'b1;
        for (int p = 1; p <= 3; p++) begin
            btn_raw = 2'b10;
            tick(10);
            btn_raw = 2'b11;
            tick(10);
            t0 = ~t0;
            checks++;
            if ({btn_level, btn_toggle} !== {2'b11, 1'b1, t0})
                $display("FAIL repress p=%0d level_toggle=%b expected=%b", p, {btn_level, btn_toggle}, {2'b11, 1'b1, t0});
            else passed++;
        end
    endtask

    task automatic test_mid_reset();
        logic [8:0] exp;
        do_reset();
        btn_raw = 2'b01;
        tick(4);
        checks++;
        if (obs !== 9'b000000001) $display("FAIL mid_check obs=%b expected=%b", obs, 9'b000000001);
        else passed++;
        rst_n = 1'b0;
        tick(1);
        checks++;
        if (obs !== 9'b0) $display("FAIL mid_reset obs=%b expected=%b", obs, 9'b0);
        else passed++;
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            exp = {1'b0, k >= 6, 1'b0, k == 7, 2'b00, 1'b0, k >= 7, (k >= 3 && k <= 5)};
            checks++;
            if (obs !== exp) $display("FAIL mid_restart k=%0d obs=%b expected=%b", k, obs, exp);
            else passed++;
        end
    endtask

    initial begin
        checks  = 0;
        passed  = 0;
        rst_n   = 1'b0;
        btn_raw = 2'b00;
        test_reset();
        test_clean_press();
        test_bounce();
        test_boundary();
        test_simultaneous();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
